// File: rtl/seg_scan_reader.sv
// seg_scan_reader: frame-snapshotted, PWM-dimmed 4-digit common-anode 7-segment scanner.
// Optional LEADING_ZERO_BLANK_EN blanks the tens-of-hours digit when it is zero.
module seg_scan_reader #(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int PWM_BITS = 8
) (
  input  logic                CLK100MHZ,
  input  logic                RESET_N,
  input  logic [3:0]          hours2,
  input  logic [3:0]          hours1,
  input  logic [3:0]          mins2,
  input  logic [3:0]          mins1,
  input  logic [PWM_BITS-1:0] pwm_in,
  output logic [7:0]          SegmentDrivers,
  output logic [7:0]          SevenSegment
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW    = DWELL > 2 ? $clog2(DWELL) : 1;
  logic [PW-1:0]       presc;
  logic [1:0]          idx;
  logic [PWM_BITS-1:0] pwm_cnt, duty_s;
  logic [3:0]          h2_s, h1_s, m2_s, m1_s, digit;
  logic                first, chg, tc, load, lit;
  logic [6:0]          seg;
  logic [7:0]          seg_out, anode;
  assign tc    = presc == PW'(DWELL - 1);
  assign load  = first | (tc & (idx == 2'd3));
  assign lit   = pwm_cnt < duty_s;
  assign digit = idx == 2'd0 ? m1_s : idx == 2'd1 ? m2_s : idx == 2'd2 ? h1_s : h2_s;
  assign anode = ~(8'd1 << idx);
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    seg_out = (idx == 2'd3 && h2_s == 4'd0) ? 8'hFF : {idx != 2'd2, seg};
`else
    seg_out = {idx != 2'd2, seg};
`endif
  end
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      presc          <= '0;
      idx            <= 2'd0;
      pwm_cnt        <= '0;
      duty_s         <= '0;
      h2_s           <= 4'd0;
      h1_s           <= 4'd0;
      m2_s           <= 4'd0;
      m1_s           <= 4'd0;
      first          <= 1'b1;
      chg            <= 1'b0;
      SegmentDrivers <= 8'hFF;
      SevenSegment   <= 8'hFF;
    end else begin
      presc   <= tc ? '0 : presc + 1'b1;
      idx     <= tc ? idx + 2'd1 : idx;
      chg     <= tc;
      pwm_cnt <= pwm_cnt + 1'b1;
      first   <= 1'b0;
      if (load) begin
        h2_s   <= hours2;
        h1_s   <= hours1;
        m2_s   <= mins2;
        m1_s   <= mins1;
        duty_s <= pwm_in;
      end
      // one dark anode cycle after each digit switch kills ghosting
      SegmentDrivers <= chg ? 8'hFF : anode;
      SevenSegment   <= lit ? seg_out : 8'hFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: directed checks of scan order, blanking, snapshotting, PWM and async reset.
module tb_seg_scan_reader;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] hours2 = 4'd1, hours1 = 4'd2, mins2 = 4'd3, mins1 = 4'd4;
  logic [7:0] pwm_in = 8'd255;
  logic [7:0] sd, ss;
  int checks = 0, errors = 0, k = 0, lit_cnt;
  seg_scan_reader #(.CLK_HZ(1000), .SCAN_HZ(100), .PWM_BITS(8)) dut (
    .CLK100MHZ(clk), .RESET_N(rst_n), .hours2(hours2), .hours1(hours1),
    .mins2(mins2), .mins1(mins1), .pwm_in(pwm_in),
    .SegmentDrivers(sd), .SevenSegment(ss)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic go_to(input int t);
    tick(t - k);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic count_lit(input int from);
    go_to(from - 1);
    lit_cnt = 0;
    repeat (256) begin
      tick(1);
      if (ss !== 8'hFF) lit_cnt++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_sd", sd, 8'hFF);
    check("rst_ss", ss, 8'hFF);
    rst_n = 1'b1;
    k = 0;
    tick(1);
    check("k1_sd", sd, 8'hFE);
    check("k1_ss_dark", ss, 8'hFF);
    tick(1);
    check("k2_sd", sd, 8'hFE);
    check("k2_ss_4", ss, 8'h99);
    go_to(10);  check("k10_sd", sd, 8'hFE);
    go_to(11);  check("ghost0", sd, 8'hFF);
    go_to(12);  check("d1_sd", sd, 8'hFD);  check("d1_ss_3", ss, 8'hB0);
    go_to(20);  check("k20_sd", sd, 8'hFD);
    go_to(21);  check("ghost1", sd, 8'hFF);
    go_to(22);  check("d2_sd", sd, 8'hFB);  check("d2_ss_2dp", ss, 8'h24);
    go_to(31);  check("ghost2", sd, 8'hFF);
    go_to(32);  check("d3_sd", sd, 8'hF7);  check("d3_ss_1", ss, 8'hF9);
    go_to(41);  check("ghost3", sd, 8'hFF);
    go_to(42);  check("wrap_sd", sd, 8'hFE); check("wrap_ss", ss, 8'h99);
    go_to(52);
    mins1 = 4'd5;
    hours2 = 4'd0;
    go_to(72);  check("tear_h2_old", ss, 8'hF9);
    go_to(82);  check("snap_m1_new", ss, 8'h92);
    mins2 = 4'hC;
    go_to(112);
`ifdef LEADING_ZERO_BLANK_EN
    check("h2_zero", ss, 8'hFF);
`else
    check("h2_zero", ss, 8'hC0);
`endif
    check("h2_zero_sd", sd, 8'hF7);
    go_to(131); check("bad_ghost", sd, 8'hFF);
    go_to(132); check("bad_sd", sd, 8'hFD); check("bad_ss", ss, 8'hFF);
    mins2 = 4'd3;
    hours2 = 4'd1;
    pwm_in = 8'd128;
    count_lit(162);
    check("duty128", lit_cnt, 128);
    pwm_in = 8'd0;
    count_lit(442);
    check("duty0", lit_cnt, 0);
    pwm_in = 8'd255;
    count_lit(722);
    check("duty255", lit_cnt, 255);
    go_to(983);
    check("pre_rst_sd", sd, 8'hFB);
    #2 rst_n = 1'b0;
    #1;
    check("async_sd", sd, 8'hFF);
    check("async_ss", ss, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick(1);
    check("rel_sd", sd, 8'hFE);
    tick(1);
    check("rel_ss", ss, 8'h92);
    go_to(11);  check("rel_ghost", sd, 8'hFF);
    go_to(12);  check("rel_d1_sd", sd, 8'hFD); check("rel_d1_ss", ss, 8'hB0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Display-side consumer of the wall-clock time digits. Takes four parallel BCD digits (HH:MM) and an 8-bit brightness word, then time-multiplexes them onto the common-anode 7-segment pins.
- Adds frame-synchronous snapshotting so a mid-scan digit change never tears. Adds PWM dimming and inter-digit ghost blanking.
- Sits between the timekeeping logic and the board's SevenSegment/SegmentDrivers pins.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, per-digit dwell rate. DWELL = CLK_HZ/SCAN_HZ clocks per digit; DWELL must be ≥ 2.
- PWM_BITS, 8, width of the brightness duty word and the PWM counter.

Ports:
- CLK100MHZ  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- hours2  in  4  BCD tens-of-hours.
- hours1  in  4  BCD units-of-hours.
- mins2  in  4  BCD tens-of-minutes.
- mins1  in  4  BCD units-of-minutes.
- pwm_in  in  PWM_BITS  brightness duty; 0 = dark.
- SegmentDrivers  out  8  digit anode enables, active-low.
- SevenSegment  out  8  segment cathodes, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - SegmentDrivers=8'hFF, SevenSegment=8'hFF.
  - Prescaler=0, digit index idx=0, PWM counter=0.
  - Shadow digits=0, shadow duty=0.
- Prescaler: counts 0..DWELL-1 and wraps. At terminal count (TC), idx advances 0→1→2→3→0.
- Frame snapshot:
  - Shadow digits and shadow duty load from the inputs on the TC cycle where idx wraps 3→0.
  - They also load on the first clock after reset release.
  - Input changes at any other time are invisible until the next frame. Frame = 4·DWELL clocks.
- Digit mapping (anode bit cleared):
  - idx0 → mins1 on bit0.
  - idx1 → mins2 on bit1.
  - idx2 → hours1 on bit2.
  - idx3 → hours2 on bit3.
  - Bits 7:4 are always 1.
- Decode, active-low {g..a}:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Codes 10–15 → blank (FF); the anode is still enabled.
- Decimal point: dp (bit7) = 0 only on idx2, as the HH.MM separator. Otherwise dp = 1.
- PWM:
  - PWM_BITS counter free-runs every clock and wraps.
  - Segments are lit when pwm_cnt < shadow duty; otherwise SevenSegment=FF and the anode stays enabled.
  - duty=0 → never lit. duty=255 → lit 255 of 256 clocks.
- Ghost blanking: on the clock following each idx change, SegmentDrivers=FF for exactly one cycle.
- Latency: outputs are registered. Pins reflect idx/pwm/shadow state one clock later.
- Reset mid-frame: outputs go FF immediately. The scan restarts at idx0 with a fresh snapshot after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: if shadow hours2 == 0, idx3 outputs SevenSegment=FF (anode timing unchanged).
- When undefined: "0" (C0) is displayed on idx3.

Test Plan:
- Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (DWELL=10, frame=40 clocks).
- Reset/idle: hold RESET_N=0 → both outputs FF. Release with digits 1,2,3,4 and duty=255 → within 2 clocks, SegmentDrivers=FE and SevenSegment=99 (mins1=4) while lit.
- Full scan, time 12:34:
  - SegmentDrivers sequence FE, FD, FB, F7, each for 10 clocks, with one FF blank cycle after each switch.
  - Segments 99, B0, 24 (2 with dp), F9.
- Tearing: change mins1 from 4 to 5 while idx=1 → idx0 keeps showing 99 until the frame wrap, then shows 92.
- PWM: duty=0 → SevenSegment constantly FF. duty=128 → lit exactly 128 of each 256 clocks. duty=255 → exactly 1 dark clock per 256.
- Invalid BCD: mins2=4'hC → idx1 outputs FF segments with anode FD. hours2=0 → C0, or FF when LEADING_ZERO_BLANK_EN is defined.
- Async reset mid-scan: assert RESET_N=0 at idx2, not on a clock edge → outputs FF before the next edge. After release, the scan restarts at idx0.
